// File: rtl/fir_sample_source_if.sv
// Handshake bundle between the FIR sample source and its controller.
// master drives buffer writes and stream control; slave is the source itself.
interface fir_sample_source_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     start;
  logic [4:0]               count;
  logic                     loop_en;
  logic                     ready;
  logic signed [DATA_W-1:0] data_out;
  logic                     sample_valid;
  logic                     busy;
  logic                     done;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output start,
    output count,
    output loop_en,
    output ready,
    input  data_out,
    input  sample_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  start,
    input  count,
    input  loop_en,
    input  ready,
    output data_out,
    output sample_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/fir_sample_source.sv
// Streams a programmable sample buffer into a FIR, optionally looping,
// then drains the filter with FLUSH_LEN zero samples.
module fir_sample_source #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int FLUSH_LEN = 4
) (
  input logic                clk,
  input logic                reset,
  fir_sample_source_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                   r_state;
  logic signed [DATA_W-1:0] r_buf [DEPTH];
  logic [AW-1:0]            r_ptr;
  logic [4:0]               r_cnt;
  logic [FW-1:0]            r_fcnt;
  logic signed [DATA_W-1:0] r_data;
  logic                     r_valid;
  logic                     r_busy;
  logic                     r_done;

  logic          w_cnt_ok;
  logic          w_xfer;
  logic          w_last;
  logic          w_flast;
  logic [AW-1:0] w_next;

  assign w_cnt_ok = (bus.count != 5'd0) &&
                    (bus.count <= 5'(DEPTH));
  assign w_xfer   = r_valid && bus.ready;
  assign w_last   = (5'(r_ptr) == (r_cnt - 5'd1));
  assign w_flast  = (r_fcnt == FW'(FLUSH_LEN - 1));
  assign w_next   = r_ptr + AW'(1);

  // Buffer is deliberately left out of reset; reads above see old data.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.wr_en)
      r_buf[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_fcnt  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start && w_cnt_ok) begin
            r_cnt   <= bus.count;
            r_ptr   <= '0;
            r_data  <= r_buf[0];
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_xfer) begin
            if (!w_last) begin
              r_ptr  <= w_next;
              r_data <= r_buf[w_next];
            end else if (bus.loop_en) begin
              r_ptr  <= '0;
              r_data <= r_buf[0];
            end else if (FLUSH_LEN == 0) begin
              r_ptr   <= '0;
              r_data  <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_ptr   <= '0;
              r_fcnt  <= '0;
              r_data  <= '0;
              r_state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (w_xfer) begin
            if (w_flast) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_fcnt <= r_fcnt + FW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out     = r_data;
  assign bus.sample_valid = r_valid;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
endmodule

// File: tb/tb_fir_sample_source.sv
// Directed bench for fir_sample_source: streaming, backpressure,
// looping, rejected starts and asynchronous abort.
module tb_fir_sample_source;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fir_sample_source_if #(.DATA_W(8), .DEPTH(8)) bus ();

  fir_sample_source #(
    .DATA_W(8),
    .DEPTH(8),
    .FLUSH_LEN(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_buf();
    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(i);
      bus.wr_data = 8'(10 * (i + 1));
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.data_out !== 8'sd0 || bus.sample_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL reset: data=%0d v=%b b=%b d=%b need 0/0/0/0",
               bus.data_out, bus.sample_valid, bus.busy, bus.done);
      n_err++;
    end
  endtask

  task automatic test_stream();
    logic signed [7:0] exp;
    bus.count   = 5'd8;
    bus.loop_en = 1'b0;
    bus.ready   = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      exp = (k < 8) ? 8'(10 * (k + 1)) : 8'sd0;
      n_cmp++;
      if (k < 12) begin
        if (bus.data_out !== exp || bus.sample_valid !== 1'b1 ||
            bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          $display("FAIL stream c%0d: data=%0d v=%b b=%b d=%b need %0d/1/1/0",
                   k + 1, bus.data_out, bus.sample_valid, bus.busy,
                   bus.done, exp);
          n_err++;
        end
      end else begin
        if (bus.sample_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b1) begin
          $display("FAIL stream_done c13: v=%b b=%b d=%b need 0/0/1",
                   bus.sample_valid, bus.busy, bus.done);
          n_err++;
        end
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL done_pulse: d=%b b=%b need 0/0", bus.done, bus.busy);
      n_err++;
    end
  endtask

  task automatic finish_stream(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (bus.data_out !== 8'sd0 || bus.sample_valid !== 1'b1 ||
          bus.done !== 1'b0) begin
        $display("FAIL %s flush%0d: data=%0d v=%b d=%b need 0/1/0",
                 name, i, bus.data_out, bus.sample_valid, bus.done);
        n_err++;
      end
      tick();
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 ||
        bus.sample_valid !== 1'b0) begin
      $display("FAIL %s end: d=%b b=%b v=%b need 1/0/0",
               name, bus.done, bus.busy, bus.sample_valid);
      n_err++;
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic signed [7:0] exp;
    bus.count   = 5'd8;
    bus.loop_en = 1'b0;
    bus.ready   = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.data_out !== 8'sd30) begin
      $display("FAIL bp_pre: data=%0d need 30", bus.data_out);
      n_err++;
    end
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.data_out !== 8'sd30 || bus.sample_valid !== 1'b1) begin
        $display("FAIL bp_hold%0d: data=%0d v=%b need 30/1",
                 i, bus.data_out, bus.sample_valid);
        n_err++;
      end
    end
    bus.ready = 1'b1;
    for (int v = 4; v <= 8; v++) begin
      tick();
      exp = 8'(10 * v);
      n_cmp++;
      if (bus.data_out !== exp || bus.sample_valid !== 1'b1) begin
        $display("FAIL bp_resume: data=%0d v=%b need %0d/1",
                 bus.data_out, bus.sample_valid, exp);
        n_err++;
      end
    end
    tick();
    finish_stream("bp", 4);
  endtask

  task automatic test_loop();
    logic signed [7:0] exp;
    bus.count   = 5'd3;
    bus.loop_en = 1'b1;
    bus.ready   = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = 8'(10 * ((k % 3) + 1));
      n_cmp++;
      if (bus.data_out !== exp || bus.sample_valid !== 1'b1) begin
        $display("FAIL loop k%0d: data=%0d need %0d",
                 k, bus.data_out, exp);
        n_err++;
      end
      if (k < 7) tick();
    end
    bus.loop_en = 1'b0;
    tick();
    n_cmp++;
    if (bus.data_out !== 8'sd30 || bus.busy !== 1'b1) begin
      $display("FAIL loop_tail: data=%0d b=%b need 30/1",
               bus.data_out, bus.busy);
      n_err++;
    end
    tick();
    finish_stream("loop", 4);
  endtask

  task automatic test_bad_start();
    bus.loop_en = 1'b0;
    bus.ready   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.count = (i == 0) ? 5'd0 : 5'd9;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n_cmp++;
      if (bus.sample_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0) begin
        $display("FAIL bad_start cnt=%0d: v=%b b=%b d=%b need 0/0/0",
                 bus.count, bus.sample_valid, bus.busy, bus.done);
        n_err++;
      end
    end
    bus.count = 5'd2;
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 8'sd99;
    tick();
    bus.wr_en = 1'b0;
    n_cmp++;
    if (bus.data_out !== 8'sd20) begin
      $display("FAIL run_write_pass1: data=%0d need 20", bus.data_out);
      n_err++;
    end
    tick();
    finish_stream("run_write", 4);
    bus.count = 5'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.data_out !== 8'sd10 || bus.sample_valid !== 1'b1) begin
      $display("FAIL run_write_pass2: data=%0d v=%b need 10/1",
               bus.data_out, bus.sample_valid);
      n_err++;
    end
    tick();
    finish_stream("single", 4);
  endtask

  task automatic test_async_reset();
    bus.count   = 5'd8;
    bus.loop_en = 1'b0;
    bus.ready   = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (bus.data_out !== 8'sd50) begin
      $display("FAIL arst_pre: data=%0d need 50", bus.data_out);
      n_err++;
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.data_out !== 8'sd0 || bus.sample_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL arst: data=%0d v=%b b=%b d=%b need 0/0/0/0",
               bus.data_out, bus.sample_valid, bus.busy, bus.done);
      n_err++;
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL arst_nodone: d=%b b=%b need 0/0", bus.done, bus.busy);
      n_err++;
    end
    bus.count = 5'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++;
    if (bus.data_out !== 8'sd10 || bus.sample_valid !== 1'b1) begin
      $display("FAIL arst_restart0: data=%0d need 10", bus.data_out);
      n_err++;
    end
    tick();
    n_cmp++;
    if (bus.data_out !== 8'sd20) begin
      $display("FAIL arst_restart1: data=%0d need 20", bus.data_out);
      n_err++;
    end
    tick();
    finish_stream("arst", 4);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.count   = '0;
    bus.loop_en = 1'b0;
    bus.ready   = 1'b0;
    #12;
    test_reset();
    reset = 1'b0;
    tick();
    load_buf();
    test_stream();
    test_backpressure();
    test_loop();
    test_bad_start();
    load_buf();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
